// File: rtl/upload_frame_packer_if.sv
// Byte-wise upload bus from the measurement handlers plus the framed byte stream
// toward the host transmitter.
interface upload_frame_packer_if;
  logic       upload_req;
  logic [7:0] upload_data;
  logic [7:0] upload_source;
  logic       upload_valid;
  logic       upload_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output upload_req, upload_data, upload_source, upload_valid,
    input  upload_ready,
    input  tx_data, tx_valid,
    output tx_ready
  );

  modport slave (
    input  upload_req, upload_data, upload_source, upload_valid,
    output upload_ready,
    output tx_data, tx_valid,
    input  tx_ready
  );
endinterface

// File: rtl/upload_frame_packer.sv
// Collects payload bytes from one source at a time and emits them as
// SYNC0 SYNC1 SRC LEN_H LEN_L PAYLOAD CSUM frames.
module upload_frame_packer #(
  parameter int         PAYLOAD_MAX  = 32,
  parameter int         IDLE_TIMEOUT = 1000,
  parameter logic [7:0] SYNC0        = 8'hAA,
  parameter logic [7:0] SYNC1        = 8'h55
) (
  input  logic                 clk,
  input  logic                 rst_n,
  upload_frame_packer_if.slave bus,
  output logic [15:0]          frames_sent
);
  localparam int AW = (PAYLOAD_MAX > 1) ? $clog2(PAYLOAD_MAX) : 1;
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT);
  localparam logic [7:0] MAX_B = 8'(PAYLOAD_MAX);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_COLLECT, ST_S0, ST_S1, ST_SRC, ST_LENH, ST_LENL, ST_PAY, ST_CSUM
  } state_t;

  state_t            state, state_next;
  logic [7:0]        count;
  logic [7:0]        rd_idx;
  logic [7:0]        rd_next;
  logic [7:0]        sum;
  logic [7:0]        cur_src;
  logic [IDLE_W-1:0] idle_cnt;
  logic [7:0]        payload_mem [2**AW];

  logic       ready;
  logic       accept;
  logic       flush;
  logic       advance;
  logic       frame_done;
  logic       tx_valid_next;
  logic [7:0] tx_data_next;
  logic       req_unused;

  // upload_req carries no meaning for acceptance
  assign req_unused = bus.upload_req;

  function automatic logic [7:0] csum_f(input logic [7:0] acc, input logic [7:0] src,
                                        input logic [7:0] len);
    return acc + src + len;
  endfunction

  always_comb begin
    state_next    = state;
    tx_valid_next = bus.tx_valid;
    tx_data_next  = bus.tx_data;
    ready         = 1'b0;
    accept        = 1'b0;
    flush         = 1'b0;
    advance       = 1'b0;
    frame_done    = 1'b0;
    rd_next       = rd_idx + 8'd1;
    case (state)
      ST_COLLECT: begin
        ready  = (count < MAX_B) && ((count == 8'd0) || (bus.upload_source == cur_src));
        accept = bus.upload_valid && ready;
        flush  = (count != 8'd0) &&
                 ((count == MAX_B) ||
                  (bus.upload_valid && (bus.upload_source != cur_src)) ||
                  (idle_cnt == IDLE_LAST));
        if (flush) begin
          state_next    = ST_S0;
          tx_valid_next = 1'b1;
          tx_data_next  = SYNC0;
        end
      end
      default: begin
        advance = bus.tx_valid && bus.tx_ready;
        if (advance) begin
          case (state)
            ST_S0: begin
              state_next   = ST_S1;
              tx_data_next = SYNC1;
            end
            ST_S1: begin
              state_next   = ST_SRC;
              tx_data_next = cur_src;
            end
            ST_SRC: begin
              state_next   = ST_LENH;
              tx_data_next = 8'h00;
            end
            ST_LENH: begin
              state_next   = ST_LENL;
              tx_data_next = count;
            end
            // count is at least 1 here, so entry 0 always holds a real byte
            ST_LENL: begin
              state_next   = ST_PAY;
              tx_data_next = payload_mem[0];
            end
            ST_PAY: begin
              if (rd_next == count) begin
                state_next   = ST_CSUM;
                tx_data_next = csum_f(sum, cur_src, count);
              end else begin
                tx_data_next = payload_mem[rd_next[AW-1:0]];
              end
            end
            default: begin
              state_next    = ST_COLLECT;
              tx_valid_next = 1'b0;
              tx_data_next  = 8'h00;
              frame_done    = 1'b1;
            end
          endcase
        end
      end
    endcase
  end

  assign bus.upload_ready = ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_COLLECT;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (accept) payload_mem[count[AW-1:0]] <= bus.upload_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= 8'd0;
      rd_idx       <= 8'd0;
      sum          <= 8'd0;
      cur_src      <= 8'd0;
      idle_cnt     <= '0;
      bus.tx_valid <= 1'b0;
      bus.tx_data  <= 8'h00;
      frames_sent  <= 16'd0;
    end else begin
      bus.tx_valid <= tx_valid_next;
      bus.tx_data  <= tx_data_next;
      if (accept) begin
        count    <= count + 8'd1;
        sum      <= sum + bus.upload_data;
        idle_cnt <= '0;
        if (count == 8'd0) cur_src <= bus.upload_source;
      end else if ((state == ST_COLLECT) && (count != 8'd0) && !flush) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end
      if (advance && (state == ST_LENL)) rd_idx <= 8'd0;
      else if (advance && (state == ST_PAY)) rd_idx <= rd_next;
      if (frame_done) begin
        count       <= 8'd0;
        sum         <= 8'd0;
        idle_cnt    <= '0;
        frames_sent <= frames_sent + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_upload_frame_packer.sv
// Scoreboard bench for upload_frame_packer: expected frame bytes are queued as
// payload is driven and popped as the packer emits them.
`timescale 1ns/1ps
module tb_upload_frame_packer;
  localparam int PAYLOAD_MAX  = 32;
  localparam int IDLE_TIMEOUT = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] frames_sent;

  upload_frame_packer_if bus();

  upload_frame_packer #(
    .PAYLOAD_MAX (PAYLOAD_MAX),
    .IDLE_TIMEOUT(IDLE_TIMEOUT),
    .SYNC0       (8'hAA),
    .SYNC1       (8'h55)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         sof_cyc = -1;
  int         rx_bytes = 0;
  bit         bp_en = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.tx_ready = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every transfer, checks stalled bytes hold.
  initial begin : monitor
    logic [7:0] held;
    logic [7:0] exp_b;
    bit         hold;
    bit         prev_v;
    hold = 1'b0;
    prev_v = 1'b0;
    held = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
        prev_v = 1'b0;
      end else begin
        if (hold) begin
          n_checks++;
          if (bus.tx_valid !== 1'b1 || bus.tx_data !== held) begin
            n_fail++;
            $display("FAIL stall_hold: tx_valid=%b tx_data=%h, required tx_valid=1 tx_data=%h",
                     bus.tx_valid, bus.tx_data, held);
          end
        end
        if (bus.tx_valid && !prev_v) sof_cyc = cyc;
        prev_v = bus.tx_valid;
        hold = bus.tx_valid && !bus.tx_ready;
        held = bus.tx_data;
        if (bus.tx_valid && bus.tx_ready) begin
          n_checks++;
          rx_bytes++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL tx_byte: got unexpected %h, required no byte", bus.tx_data);
          end else begin
            exp_b = exp_q.pop_front();
            if (bus.tx_data !== exp_b) begin
              n_fail++;
              $display("FAIL tx_byte: got %h, required %h", bus.tx_data, exp_b);
            end
          end
        end
      end
    end
  end

  task automatic push_frame(input logic [7:0] s, input logic [7:0] p[$]);
    logic [7:0] cs;
    logic [7:0] len;
    len = 8'(p.size());
    cs = s + len;
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    exp_q.push_back(s);
    exp_q.push_back(8'h00);
    exp_q.push_back(len);
    foreach (p[i]) begin
      exp_q.push_back(p[i]);
      cs = cs + p[i];
    end
    exp_q.push_back(cs);
  endtask

  task automatic send_byte(input logic [7:0] s, input logic [7:0] d, output int acc_cyc);
    int n = 0;
    @(negedge clk);
    bus.upload_req = 1'b1;
    bus.upload_valid = 1'b1;
    bus.upload_source = s;
    bus.upload_data = d;
    #1;
    while (bus.upload_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    n_checks++;
    if (n >= 5000) begin
      n_fail++;
      $display("FAIL send_accept: byte %h src %h waited %0d cycles, required acceptance", d, s, n);
    end
    acc_cyc = cyc;
    @(posedge clk);
  endtask

  task automatic send_pay(input logic [7:0] s, input logic [7:0] p[$], output int last_cyc);
    push_frame(s, p);
    last_cyc = 0;
    foreach (p[i]) send_byte(s, p[i], last_cyc);
    @(negedge clk);
    bus.upload_valid = 1'b0;
    bus.upload_req = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || bus.tx_valid) && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0 || bus.tx_valid) begin
      n_fail++;
      $display("FAIL %s_drain: %0d bytes outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic check_frames(input string name, input logic [15:0] expv);
    n_checks++;
    if (frames_sent !== expv) begin
      n_fail++;
      $display("FAIL %s_frames_sent: got %h, required %h", name, frames_sent, expv);
    end
  endtask

  task automatic test_reset();
    bus.upload_req = 1'b0;
    bus.upload_valid = 1'b0;
    bus.upload_source = 8'h00;
    bus.upload_data = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks += 3;
    if (bus.tx_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_tx_valid: got %b, required 0", bus.tx_valid);
    end
    if (bus.tx_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_tx_data: got %h, required 00", bus.tx_data);
    end
    if (bus.upload_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_upload_ready: got %b, required 1", bus.upload_ready);
    end
    check_frames("reset", 16'h0000);
    rst_n = 1'b1;
  endtask

  task automatic test_timeout_flush();
    logic [7:0] p[$];
    int last;
    p.push_back(8'h01); p.push_back(8'h02); p.push_back(8'h03);
    send_pay(8'h03, p, last);
    wait_drain("timeout", 3000);
    n_checks++;
    if (sof_cyc - last !== IDLE_TIMEOUT + 1) begin
      n_fail++;
      $display("FAIL timeout_latency: frame start %0d cycles after last byte, required %0d",
               sof_cyc - last, IDLE_TIMEOUT + 1);
    end
    check_frames("timeout", 16'd1);
  endtask

  task automatic test_full_flush();
    logic [7:0] p[$];
    int last;
    for (int i = 0; i < PAYLOAD_MAX; i++) p.push_back(8'(i));
    send_pay(8'h01, p, last);
    #1;
    n_checks++;
    if (bus.upload_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_ready_drop: upload_ready=%b, required 0", bus.upload_ready);
    end
    wait_drain("full", 200);
    n_checks++;
    if (sof_cyc - last !== 2) begin
      n_fail++;
      $display("FAIL full_latency: frame start %0d cycles after last byte, required 2", sof_cyc - last);
    end
    check_frames("full", 16'd2);
  endtask

  task automatic test_source_switch();
    logic [7:0] p1[$];
    logic [7:0] p2[$];
    int last;
    int acc;
    p1.push_back(8'hAB); p1.push_back(8'hCD);
    p2.push_back(8'h77);
    push_frame(8'h03, p1);
    send_byte(8'h03, 8'hAB, last);
    send_byte(8'h03, 8'hCD, last);
    @(negedge clk);
    bus.upload_source = 8'h02;
    bus.upload_data = 8'h77;
    #1;
    n_checks++;
    if (bus.upload_ready !== 1'b0) begin
      n_fail++; $display("FAIL switch_holdoff: upload_ready=%b, required 0", bus.upload_ready);
    end
    push_frame(8'h02, p2);
    send_byte(8'h02, 8'h77, acc);
    n_checks += 2;
    if (sof_cyc - last !== 2) begin
      n_fail++;
      $display("FAIL switch_latency: frame start %0d cycles after last byte, required 2", sof_cyc - last);
    end
    if (acc - last !== 10) begin
      n_fail++;
      $display("FAIL switch_accept: new byte accepted %0d cycles after last byte, required 10", acc - last);
    end
    @(negedge clk);
    bus.upload_valid = 1'b0;
    wait_drain("switch", 3000);
    check_frames("switch", 16'd4);
  endtask

  task automatic test_backpressure();
    logic [7:0] p[$];
    int last;
    int rx0;
    rx0 = rx_bytes;
    p.push_back(8'h01); p.push_back(8'h02); p.push_back(8'h03);
    bp_en = 1'b1;
    send_pay(8'h03, p, last);
    wait_drain("backpressure", 3000);
    bp_en = 1'b0;
    n_checks++;
    if (rx_bytes - rx0 !== 9) begin
      n_fail++; $display("FAIL bp_byte_count: got %0d bytes, required 9", rx_bytes - rx0);
    end
    check_frames("backpressure", 16'd5);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] p[$];
    logic [7:0] q[$];
    int last;
    int base;
    int n = 0;
    p.push_back(8'h11); p.push_back(8'h22); p.push_back(8'h33); p.push_back(8'h44);
    base = rx_bytes;
    send_pay(8'h09, p, last);
    while (rx_bytes < base + 6 && n < 3000) begin
      @(negedge clk);
      #2;
      n++;
    end
    n_checks++;
    if (rx_bytes < base + 6) begin
      n_fail++; $display("FAIL midreset_reach_pay: got %0d bytes, required 6", rx_bytes - base);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.tx_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_tx_valid: got %b, required 0", bus.tx_valid);
    end
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.upload_ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset_upload_ready: got %b, required 1", bus.upload_ready);
    end
    check_frames("midreset", 16'd0);
    q.push_back(8'h10);
    send_pay(8'h05, q, last);
    wait_drain("postreset", 3000);
    check_frames("postreset", 16'd1);
  endtask

  task automatic test_counter_wrap();
    logic [7:0] p[$];
    int last;
    @(negedge clk);
    force dut.frames_sent = 16'hFFFF;
    @(negedge clk);
    release dut.frames_sent;
    p.push_back(8'h42);
    send_pay(8'h06, p, last);
    wait_drain("wrap", 3000);
    check_frames("wrap", 16'h0000);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_timeout_flush();
    test_full_flush();
    test_source_switch();
    test_backpressure();
    test_reset_mid_frame();
    test_counter_wrap();
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/upload_frame_packer.md
# upload_frame_packer

Downstream consumer of the measurement handlers' byte-wise upload interface (`upload_req`/`upload_data`/`upload_source`/`upload_valid`/`upload_ready`). It buffers payload bytes from one source at a time and emits them as checksummed frames on a byte stream toward the host transmitter (USB/UART TX). A frame is flushed when one of three conditions occurs:

- the payload buffer is full;
- an idle timeout expires;
- a byte from a different source arrives.

## Interface

Parameters:

- `PAYLOAD_MAX`, default 32: payload bytes per frame, legal range 1..255.
- `IDLE_TIMEOUT`, default 1000: number of clock cycles without an accepted byte before a partial frame is flushed. Must be at least 2.
- `SYNC0`, default 8'hAA: first sync byte.
- `SYNC1`, default 8'h55: second sync byte.

Ports (clock and reset first):

- `clk`  in  1  one clock for the whole block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `upload_req`  in  1  source request; informational only, it does not gate acceptance.
- `upload_data`  in  8  payload byte.
- `upload_source`  in  8  source ID of the current byte.
- `upload_valid`  in  1  byte valid.
- `upload_ready`  out  1  byte accepted on any cycle where `upload_valid && upload_ready`.
- `tx_data`  out  8  framed output byte.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  downstream accepts the byte on `tx_valid && tx_ready`.
- `frames_sent`  out  16  count of completed frames; wraps from 16'hFFFF to 0.

## Operation

**Frame format**, in transmission order:

- `SYNC0`, `SYNC1`
- SRC
- LEN_H, LEN_L (payload length, 16-bit)
- PAYLOAD[0..LEN-1]
- CSUM

CSUM is the sum modulo 256 of SRC, LEN_H, LEN_L and all payload bytes. The sync bytes are excluded.

**States:** COLLECT, S0, S1, SRC, LENH, LENL, PAY, CSUM.

**COLLECT**
- `upload_ready = (count < PAYLOAD_MAX) && (count == 0 || upload_source == cur_src)`. This is combinational from state, `count`, `cur_src` and `upload_source`.
- On an accepted byte: write the byte into `buf[count]`, increment `count`, add the byte to `sum`, and clear `idle_cnt`. If `count` was 0, latch `cur_src` from `upload_source`.
- Flush triggers. Any one moves the block to S0 on the next edge:
  - `count == PAYLOAD_MAX`;
  - `count > 0 && upload_valid && upload_source != cur_src` (the mismatching byte is not accepted);
  - `count > 0 && idle_cnt == IDLE_TIMEOUT-1`.
- `idle_cnt` increments every COLLECT cycle where `count > 0` and no byte is accepted. It holds at 0 while `count == 0`.
- With `count == 0`, the block never flushes. Empty frames do not exist.

**Send states (S0 through CSUM)**
- `upload_ready = 0`.
- `tx_valid = 1`, and `tx_data` carries the byte for the current state.
- A state advances only on `tx_valid && tx_ready`.
- PAY steps a read index from 0 to `count-1`.
- When the CSUM byte is accepted: increment `frames_sent`, clear `count`, `sum` and `idle_cnt`, and return to COLLECT.

**Arithmetic and registers**
- `count` and the read index are 8 bits.
- LEN_H is always 8'h00; LEN_L equals `count`.
- `sum` is an 8-bit accumulator that wraps. CSUM = `sum + cur_src + count` modulo 256.
- `tx_data` and `tx_valid` are registered outputs.

**Reset (asynchronous, any time including mid-frame)**
- The partial buffer and any in-flight frame are discarded.
- State becomes COLLECT; `count`, `idle_cnt`, `sum` and `cur_src` are cleared to 0.
- `tx_valid = 0`, `tx_data = 8'h00`, `frames_sent = 0`.
- `upload_ready` reads 1 after reset (COLLECT with empty buffer).

## Timing

- A flush trigger in cycle N puts `SYNC0` on `tx_data` with `tx_valid` high in cycle N+1.
- With `tx_ready` held high, a frame takes `count + 6` consecutive cycles. `upload_ready` returns high in the cycle after CSUM is accepted.
- Under backpressure (`tx_valid && !tx_ready`), `tx_data` and the state hold stable.
- Timeout: the last byte is accepted at cycle T. The frame starts at T + `IDLE_TIMEOUT` + 1.
- Buffer full: the `PAYLOAD_MAX`-th byte is accepted at cycle N. `upload_ready` is low from cycle N+1, and S0 is output at N+2.
- A byte whose source mismatches while `count == 0` is accepted normally and starts a new frame.

## Test plan

- **Timeout flush:** source 8'h03 sends 8'h01, 8'h02, 8'h03, then goes idle -> after `IDLE_TIMEOUT` cycles the output is AA 55 03 00 03 01 02 03 0C; `frames_sent` = 1.
- **Full flush:** source 8'h01 sends 8'h00 through 8'h1F back-to-back -> `upload_ready` drops after the 32nd byte; output is AA 55 01 00 20 00..1F 11, with no timeout wait.
- **Source switch:** source 8'h03 sends 8'hAB, 8'hCD, then source 8'h02 presents 8'h77 -> 8'h77 is held off. First frame is AA 55 03 00 02 AB CD 7D. 8'h77 is then accepted, and after timeout the output is AA 55 02 00 01 77 7A.
- **Backpressure:** `tx_ready` toggles 1,0,0,1 pseudo-randomly during the frame -> byte sequence identical to the no-backpressure case; `tx_data` stable whenever `tx_valid && !tx_ready`; no bytes are duplicated or dropped.
- **Reset mid-frame:** assert `rst_n` low during PAY -> `tx_valid` goes to 0 immediately; after release `frames_sent` = 0 and `upload_ready` = 1. A new 1-byte frame from source 8'h05 with byte 8'h10 produces AA 55 05 00 01 10 16.
- **Counter wrap:** preload or run to `frames_sent` = 16'hFFFF, then send one frame -> `frames_sent` = 16'h0000.
